// File: rtl/demux_stream_pkg.sv
// Shared types and helpers for the streaming demultiplexer.
// Holds the slot state encoding and the select-width helper.
package demux_stream_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Select width is clog2 of the channel count, never narrower than one bit.
  function automatic int sel_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/demux_stream_if.sv
// Producer-side and consumer-side bundle of the streaming demultiplexer.
// The master modport is the bench/producer view, the slave modport is the block's view.
interface demux_stream_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int ERR_W  = 8
);
  import demux_stream_pkg::*;

  localparam int SEL_W = sel_width(N_OUT);

  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_bcast;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [ERR_W-1:0]        err_cnt;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_cnt
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_cnt
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry output holding slot: EMPTY/FULL state plus the held word.
// The top only raises load_i when free_o is high, so a stalled FULL slot is never overwritten.
module demux_slot
  import demux_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              free_o,
  output logic [DATA_W-1:0] data_o
);

  slot_state_e       state_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: state is updated with non-blocking assignments so every slot samples the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      // NOTE: the data register is reset too because out_data must read zero after reset.
      data_q  <= '0;
    end else if (load_i) begin
      state_q <= SLOT_FULL;
      data_q  <= data_i;
    end else if (ready_i) begin
      state_q <= SLOT_EMPTY;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign free_o  = !valid_o || ready_i;
  assign data_o  = data_q;

endmodule

// File: rtl/demux_stream.sv
// 1-to-N streaming demultiplexer with per-channel holding slots, broadcast and a
// saturating drop counter for out-of-range selects.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int ERR_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  demux_stream_if.slave  bus
);

  localparam int SEL_W = sel_width(N_OUT);

  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] load;
  logic             in_range;
  logic             sel_free;
  logic             in_ready;
  logic             accept;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;

  // Compare at full integer width so a power-of-two N_OUT does not wrap.
  assign in_range = int'(bus.in_sel) < N_OUT;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_free = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (bus.in_sel == SEL_W'(k)) sel_free = free[k];
    end
  end

  // Broadcast waits for every slot so it is never delivered partially.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (bus.in_bcast)  in_ready = &free;
      else if (in_range) in_ready = sel_free;
      else               in_ready = 1'b1;
    end
  end

  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  always_comb begin
    err_d = err_q;
    if (accept && !bus.in_bcast && !in_range && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign bus.err_cnt = err_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign load[k] = accept && (bus.in_bcast || (in_range && (bus.in_sel == SEL_W'(k))));

    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[k]),
      .data_i  (bus.in_data),
      .ready_i (bus.out_ready[k]),
      .valid_o (bus.out_valid[k]),
      .free_o  (free[k]),
      .data_o  (bus.out_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: a 4-channel instance checked against a per-channel
// scoreboard, plus a 3-channel instance for the out-of-range drop path.
module tb_demux_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] sb [4][$];

  demux_stream_if #(.DATA_W(8), .N_OUT(4), .ERR_W(8)) b4 ();
  demux_stream_if #(.DATA_W(8), .N_OUT(3), .ERR_W(8)) b3 ();

  demux_stream #(.DATA_W(8), .N_OUT(4), .ERR_W(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  demux_stream #(.DATA_W(8), .N_OUT(3), .ERR_W(8)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of the 4-channel instance: compare drains, record accepts, advance.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ch%0d_valid", k), 32'(b4.out_valid[k]), 32'(sb[k].size() != 0));
      if (b4.out_valid[k] && b4.out_ready[k] && (sb[k].size() != 0))
        check($sformatf("ch%0d_data", k), 32'(b4.out_data[k*8 +: 8]), 32'(sb[k].pop_front()));
    end
    if (b4.in_valid && b4.in_ready) begin
      if (b4.in_bcast) for (int k = 0; k < 4; k++) sb[k].push_back(b4.in_data);
      else             sb[b4.in_sel].push_back(b4.in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic bc);
    b4.in_data  = d;
    b4.in_sel   = s;
    b4.in_bcast = bc;
    b4.in_valid = 1'b1;
    #1;
  endtask

  initial begin
    int exp_err;
    b4.in_data = 8'h00; b4.in_sel = 2'd0; b4.in_bcast = 1'b0; b4.in_valid = 1'b1;
    b4.out_ready = 4'b0000;
    b3.in_data = 8'h00; b3.in_sel = 2'd0; b3.in_bcast = 1'b0; b3.in_valid = 1'b0;
    b3.out_ready = 3'b000;

    // Reset state, with a word already offered
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(b4.out_valid), 32'h0);
    check("rst_out_data",  b4.out_data, 32'h0);
    check("rst_err_cnt",   32'(b3.err_cnt), 32'h0);
    check("rst_in_ready",  32'(b4.in_ready), 32'h0);
    b4.in_valid = 1'b0;
    rst = 1'b0;
    step();

    // Unicast streaming to channel 1
    b4.out_ready = 4'b1111;
    send(8'h11, 2'd1, 1'b0); check("uni_ready0", 32'(b4.in_ready), 32'h1); step();
    send(8'h22, 2'd1, 1'b0); check("uni_ready1", 32'(b4.in_ready), 32'h1); step();
    send(8'h33, 2'd1, 1'b0); check("uni_ready2", 32'(b4.in_ready), 32'h1); step();
    b4.in_valid = 1'b0;
    step();
    step();

    // Backpressure on channel 3
    b4.out_ready = 4'b0111;
    send(8'hA5, 2'd3, 1'b0); check("bp_ready_first", 32'(b4.in_ready), 32'h1); step();
    send(8'h5A, 2'd3, 1'b0); check("bp_ready_second", 32'(b4.in_ready), 32'h0); step();
    check("bp_hold_data0", 32'(b4.out_data[31:24]), 32'hA5);
    step();
    check("bp_hold_data1", 32'(b4.out_data[31:24]), 32'hA5);
    b4.out_ready = 4'b1111;
    #1;
    check("bp_ready_release", 32'(b4.in_ready), 32'h1);
    step();
    b4.in_valid = 1'b0;
    check("bp_reload_data", 32'(b4.out_data[31:24]), 32'h5A);
    step();
    step();

    // Broadcast blocked by a stalled slot 0
    b4.out_ready = 4'b0000;
    send(8'h3C, 2'd0, 1'b0); step();
    b4.out_ready = 4'b1110;
    send(8'h7E, 2'd2, 1'b1); check("bc_blocked", 32'(b4.in_ready), 32'h0); step();
    check("bc_no_change_valid", 32'(b4.out_valid), 32'h1);
    check("bc_no_change_data",  32'(b4.out_data[7:0]), 32'h3C);
    b4.out_ready = 4'b1111;
    #1;
    check("bc_unblocked", 32'(b4.in_ready), 32'h1);
    step();
    b4.in_valid = 1'b0;
    check("bc_all_valid", 32'(b4.out_valid), 32'hF);
    check("bc_all_data",  b4.out_data, 32'h7E7E7E7E);
    step();
    step();

    // Independent drain: slot 0 drains, slot 2 holds, slot 1 still accepts
    b4.out_ready = 4'b0000;
    send(8'h44, 2'd0, 1'b0); step();
    send(8'h66, 2'd2, 1'b0); step();
    b4.in_valid = 1'b0;
    b4.out_ready = 4'b0001;
    step();
    b4.out_ready = 4'b0000;
    check("ind_valid_after_drain", 32'(b4.out_valid), 32'h4);
    check("ind_slot2_hold", 32'(b4.out_data[23:16]), 32'h66);
    send(8'h99, 2'd1, 1'b0); check("ind_ready_slot1", 32'(b4.in_ready), 32'h1); step();
    b4.in_valid = 1'b0;
    check("ind_valid_slot1", 32'(b4.out_valid), 32'h6);
    check("ind_slot2_still", 32'(b4.out_data[23:16]), 32'h66);
    b4.out_ready = 4'b1111;
    step();
    step();

    // Out-of-range select on the 3-channel instance: drop and saturate
    b3.out_ready = 3'b111;
    b3.in_data   = 8'hFF;
    b3.in_sel    = 2'd3;
    b3.in_valid  = 1'b1;
    exp_err = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check("oor_ready", 32'(b3.in_ready), 32'h1);
      check("oor_no_valid", 32'(b3.out_valid), 32'h0);
      check("oor_err_cnt", 32'(b3.err_cnt), 32'(exp_err));
      if (exp_err < 255) exp_err++;
      @(posedge clk);
      #1;
    end
    check("oor_saturated", 32'(b3.err_cnt), 32'd255);
    b3.out_ready = 3'b000;
    b3.in_data   = 8'h5C;
    b3.in_sel    = 2'd2;
    #1;
    check("n3_ready_in_range", 32'(b3.in_ready), 32'h1);
    @(posedge clk);
    #1;
    check("n3_valid_slot2", 32'(b3.out_valid), 32'h4);
    check("n3_data_slot2", 32'(b3.out_data[23:16]), 32'h5C);
    check("n3_err_unchanged", 32'(b3.err_cnt), 32'd255);

    // Asynchronous reset mid-stream with slot 2 full and a word pending
    b4.out_ready = 4'b0000;
    send(8'h21, 2'd2, 1'b0); step();
    send(8'h22, 2'd2, 1'b0); check("mid_blocked", 32'(b4.in_ready), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid",     32'(b4.out_valid), 32'h0);
    check("mid_rst_in_ready",  32'(b4.in_ready), 32'h0);
    check("mid_rst_err_cnt",   32'(b3.err_cnt), 32'h0);
    check("mid_rst_n3_valid",  32'(b3.out_valid), 32'h0);
    check("mid_rst_n3_ready",  32'(b3.in_ready), 32'h0);
    for (int k = 0; k < 4; k++) sb[k].delete();
    @(posedge clk);
    #1;
    check("mid_rst_not_accepted", 32'(b4.out_valid), 32'h0);
    check("mid_rst_ready_held",   32'(b4.in_ready), 32'h0);
    b4.in_valid = 1'b0;
    b3.in_valid = 1'b0;
    rst = 1'b0;
    b4.out_ready = 4'b1111;
    step();
    step();

    for (int k = 0; k < 4; k++) check($sformatf("sb%0d_empty", k), 32'(sb[k].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
